sram_wb_ctrl: RTL and testbench



---
 rtl/sram_wb_ctrl_pkg.sv | 16 +
 rtl/sram_init_seq.sv | 42 ++++
 rtl/sram_wb_ctrl.sv | 126 ++++++++++++
 tb/tb_sram_wb_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_wb_ctrl_pkg.sv
// Shared state encodings and constants for the Wishbone-to-OpenRAM port-0 controller.
package sram_wb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_NUM_WMASKS = 4;
    localparam int unsigned DEPTH          = 1 << DEF_ADDR_WIDTH;
    localparam logic [DEF_NUM_WMASKS-1:0] FULL_MASK = {DEF_NUM_WMASKS{1'b1}};

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset clear sweep: walks every word address once, then raises done a cycle later.
module sram_init_seq
    import sram_wb_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_active,
    output logic                  o_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_active;
    logic                  r_done;

    // Done trails the active flag by one edge so the FSM has registered the last write first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr   <= '0;
            r_active <= INIT_EN;
            r_done   <= !INIT_EN;
        end else if (r_active) begin
            if (r_addr == LAST_ADDR) begin
                r_active <= 1'b0;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end else if (!r_done) begin
            r_done <= 1'b1;
        end
    end

    assign o_addr   = r_addr;
    assign o_active = r_active;
    assign o_done   = r_done;

endmodule

// File: rtl/sram_wb_ctrl.sv
// Wishbone-classic target for port 0 of a 256x32 OpenRAM macro with byte-write mask.
module sram_wb_ctrl
    import sram_wb_ctrl_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          NUM_WMASKS = DEF_NUM_WMASKS,
    parameter bit                   INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [ADDR_WIDTH+1:0]   i_wb_adr,
    input  logic [DATA_WIDTH-1:0]   i_wb_dat,
    input  logic [NUM_WMASKS-1:0]   i_wb_sel,
    input  logic                    i_wb_we,
    input  logic                    i_wb_stb,
    output logic [DATA_WIDTH-1:0]   o_wb_rdt,
    output logic                    o_wb_ack,
    output logic                    o_init_done,
    output logic                    o_sram_csb,
    output logic                    o_sram_web,
    output logic [NUM_WMASKS-1:0]   o_sram_wmask,
    output logic [ADDR_WIDTH-1:0]   o_sram_addr,
    output logic [DATA_WIDTH-1:0]   o_sram_din,
    input  logic [DATA_WIDTH-1:0]   i_sram_dout
);

    localparam logic [NUM_WMASKS-1:0] ALL_LANES = {NUM_WMASKS{1'b1}};

    state_t                  r_state;
    logic                    r_we;
    logic                    r_ack;
    logic [DATA_WIDTH-1:0]   r_rdt;
    logic                    r_csb;
    logic                    r_web;
    logic [NUM_WMASKS-1:0]   r_wmask;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_din;

    logic [ADDR_WIDTH-1:0]   w_init_addr;
    logic                    w_init_active;
    logic                    w_init_done;
    logic                    w_unused_adr;

    assign w_unused_adr = &{1'b0, i_wb_adr[1:0]};

    sram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_EN    (INIT_EN)
    ) u_init_seq (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .o_addr   (w_init_addr),
        .o_active (w_init_active),
        .o_done   (w_init_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= INIT_EN ? ST_INIT : ST_IDLE;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_rdt   <= '0;
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                ST_INIT: begin
                    if (w_init_active) begin
                        r_csb   <= 1'b0;
                        r_web   <= 1'b0;
                        r_wmask <= ALL_LANES;
                        r_addr  <= w_init_addr;
                        r_din   <= INIT_VALUE;
                    end else begin
                        r_csb   <= 1'b1;
                        r_web   <= 1'b1;
                        r_wmask <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (i_wb_stb) begin
                        r_csb   <= 1'b0;
                        r_web   <= ~i_wb_we;
                        r_wmask <= i_wb_we ? i_wb_sel : '0;
                        r_addr  <= i_wb_adr[ADDR_WIDTH+1:2];
                        r_din   <= i_wb_dat;
                        r_we    <= i_wb_we;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_csb <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_csb   <= 1'b1;
                    r_web   <= 1'b1;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    // Capture on this edge, before the macro's dout hold window expires.
                    r_ack <= 1'b1;
                    if (!r_we) begin
                        r_rdt <= i_sram_dout;
                    end
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wb_ack     = r_ack;
    assign o_wb_rdt     = r_rdt;
    assign o_init_done  = w_init_done;
    assign o_sram_csb   = r_csb;
    assign o_sram_web   = r_web;
    assign o_sram_wmask = r_wmask;
    assign o_sram_addr  = r_addr;
    assign o_sram_din   = r_din;

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Scoreboard bench for sram_wb_ctrl against a behavioural 256x32 byte-masked macro model.
module tb_sram_wb_ctrl;
    import sram_wb_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  i_wb_adr = '0;
    logic [31:0] i_wb_dat = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        i_wb_we  = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_init_done;
    logic        o_sram_csb;
    logic        o_sram_web;
    logic [3:0]  o_sram_wmask;
    logic [7:0]  o_sram_addr;
    logic [31:0] o_sram_din;
    logic [31:0] sram_dout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] macro_mem [DEPTH];
    logic [31:0] ref_mem   [DEPTH];
    logic [31:0] last_rd;
    logic [31:0] sbq [$];
    logic        prev_ack;

    always #5 clk = ~clk;

    sram_wb_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wb_adr     (i_wb_adr),
        .i_wb_dat     (i_wb_dat),
        .i_wb_sel     (i_wb_sel),
        .i_wb_we      (i_wb_we),
        .i_wb_stb     (i_wb_stb),
        .o_wb_rdt     (o_wb_rdt),
        .o_wb_ack     (o_wb_ack),
        .o_init_done  (o_init_done),
        .o_sram_csb   (o_sram_csb),
        .o_sram_web   (o_sram_web),
        .o_sram_wmask (o_sram_wmask),
        .o_sram_addr  (o_sram_addr),
        .o_sram_din   (o_sram_din),
        .i_sram_dout  (sram_dout)
    );

    // Behavioural macro: samples controls on the rising edge, dout follows a read.
    always @(posedge clk) begin
        if (!o_sram_csb) begin
            if (!o_sram_web) begin
                logic [31:0] w;
                w = macro_mem[o_sram_addr];
                for (int b = 0; b < 4; b++)
                    if (o_sram_wmask[b]) w[8*b +: 8] = o_sram_din[8*b +: 8];
                macro_mem[o_sram_addr] <= w;
            end else begin
                sram_dout <= macro_mem[o_sram_addr];
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic model_cleared();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        last_rd = 32'h0;
    endtask

    task automatic wait_done(input string name);
        int cnt;
        cnt = 0;
        while (!o_init_done && cnt < 400) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk(name, {31'd0, o_init_done}, 32'd1);
    endtask

    task automatic do_op(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit chk_lat);
        int cnt;
        bit got;
        logic [7:0] w;
        w = adr[9:2];
        if (we) ref_mem[w] = merge(ref_mem[w], dat, sel);
        else    last_rd = ref_mem[w];
        sbq.push_back(last_rd);
        @(negedge clk);
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_stb = 1'b1;
        cnt = 0;
        got = 0;
        while (!got && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (o_wb_ack) got = 1;
        end
        i_wb_stb = 1'b0;
        if (!got) chk("ack_timeout", 32'(cnt), 32'd0);
        else if (chk_lat) chk("ack_latency", 32'(cnt), 32'd3);
    endtask

    initial begin
        int cnt;
        int done_at;
        bit got;
        prev_ack = 1'b0;
        model_cleared();

        fork
            begin
                #2000000;
                $display("FAIL watchdog: got timeout, expected finish");
                $fatal(1, "watchdog");
            end
            forever begin
                @(negedge clk);
                if (o_wb_ack) begin
                    chk("ack_pulse_width", {31'd0, prev_ack}, 32'd0);
                    if (sbq.size() == 0) begin
                        chk("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        chk("rdt", o_wb_rdt, sbq.pop_front());
                    end
                end
                prev_ack = o_wb_ack;
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack",   {31'd0, o_wb_ack},    32'd0);
        chk("rst_rdt",   o_wb_rdt,             32'd0);
        chk("rst_done",  {31'd0, o_init_done}, 32'd0);
        chk("rst_csb",   {31'd0, o_sram_csb},  32'd1);
        chk("rst_web",   {31'd0, o_sram_web},  32'd1);
        chk("rst_wmask", {28'd0, o_sram_wmask}, 32'd0);
        chk("rst_addr",  {24'd0, o_sram_addr}, 32'd0);
        chk("rst_din",   o_sram_din,           32'd0);

        // Sweep length and mid-sweep controls
        rst = 1'b0;
        cnt = 0;
        got = 0;
        while (!got && cnt < 400) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (cnt == 100) begin
                chk("sweep_csb",   {31'd0, o_sram_csb}, 32'd0);
                chk("sweep_addr",  {24'd0, o_sram_addr}, 32'd99);
                chk("sweep_wmask", {28'd0, o_sram_wmask}, 32'hF);
            end
            if (o_init_done) got = 1;
        end
        chk("done_cycles", 32'(cnt), 32'd257);

        do_op(1'b0, 10'h000, 32'h0, 4'h0, 1'b1);
        do_op(1'b0, 10'h1FC, 32'h0, 4'h0, 1'b1);
        do_op(1'b0, 10'h3FC, 32'h0, 4'h0, 1'b1);

        do_op(1'b1, 10'h010, 32'hDEADBEEF, 4'b1111, 1'b1);
        do_op(1'b0, 10'h010, 32'h0, 4'h0, 1'b1);
        do_op(1'b1, 10'h010, 32'h11223344, 4'b0101, 1'b1);
        do_op(1'b0, 10'h010, 32'h0, 4'h0, 1'b1);
        chk("merge_0101", ref_mem[4], 32'hDE22BE44);
        do_op(1'b1, 10'h010, 32'hFFFFFFFF, 4'b0000, 1'b1);
        do_op(1'b0, 10'h010, 32'h0, 4'h0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [9:0] a;
            a = {4'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            do_op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 1'b1);
        end

        // Request held off by the sweep
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_cleared();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        sbq.push_back(32'h0);
        i_wb_we  = 1'b0;
        i_wb_adr = 10'h010;
        i_wb_stb = 1'b1;
        cnt = 10;
        done_at = 0;
        got = 0;
        while (!got && cnt < 500) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (o_init_done && done_at == 0) done_at = cnt;
            if (o_wb_ack) got = 1;
        end
        i_wb_stb = 1'b0;
        chk("sweep_hold_done", {31'd0, o_init_done}, 32'd1);
        chk("sweep_hold_lat",  32'(cnt), 32'(done_at + 3));

        // Reset during the ISSUE cycle of a write
        do_op(1'b1, 10'h020, 32'h12345678, 4'hF, 1'b1);
        @(negedge clk);
        i_wb_we  = 1'b1;
        i_wb_adr = 10'h020;
        i_wb_dat = 32'hCAFEF00D;
        i_wb_sel = 4'hF;
        i_wb_stb = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_wb_stb = 1'b0;
        #1;
        chk("abort_csb", {31'd0, o_sram_csb}, 32'd1);
        chk("abort_ack", {31'd0, o_wb_ack},   32'd0);
        repeat (3) @(negedge clk);
        chk("abort_rdt", o_wb_rdt, 32'd0);
        model_cleared();
        rst = 1'b0;
        wait_done("resweep_done");
        do_op(1'b0, 10'h020, 32'h0, 4'h0, 1'b1);
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
